// File: rtl/sram_pkg.sv
// Shared definitions for the asynchronous-SRAM responder: FSM encodings,
// synchronizer depth and the bundled control-strobe type.
package sram_pkg;

    localparam int SYNC_DEPTH = 2;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WRITE    = 2'd1;
    localparam logic [1:0] ST_READ     = 2'd2;
    localparam logic [1:0] ST_CONFLICT = 2'd3;

    typedef struct packed {
        logic ce;
        logic oe_l;
        logic we_l;
    } ctrl_t;

    // Inactive bus levels; the synchronizer resets to these.
    localparam ctrl_t CTRL_IDLE = '{ce: 1'b0, oe_l: 1'b1, we_l: 1'b1};

    function automatic logic is_conflict(input ctrl_t c);
        return c.ce & ~c.oe_l & ~c.we_l;
    endfunction

    function automatic logic is_write_req(input ctrl_t c);
        return c.ce & c.oe_l & ~c.we_l;
    endfunction

    function automatic logic is_read_req(input ctrl_t c);
        return c.ce & ~c.oe_l & c.we_l;
    endfunction

endpackage

// File: rtl/sram_array.sv
// Single-port-write, registered-read memory; contents are never reset.
module sram_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sram_responder.sv
// Emulates an asynchronous SRAM on a shared bus: all pins are synchronized,
// writes commit on the we_l rising edge, reads drive the bus from a register.
module sram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       ram_addr,
    input  logic              ram_ce,
    input  logic              ram_oe_l,
    input  logic              ram_we_l,
    inout  wire  [DATA_W-1:0] ram_data,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count,
    output logic              conflict
);

    localparam int SYNC_W = $bits(ctrl_t) + 16 + DATA_W;
    localparam logic [SYNC_W-1:0] SYNC_RST = {CTRL_IDLE, {(16 + DATA_W){1'b0}}};

    // Synchronizer: every pin travels through the same number of stages so
    // address and data stay aligned with the strobes that qualify them.
    logic [SYNC_W-1:0] sync_in  [SYNC_DEPTH];
    logic [SYNC_W-1:0] sync_reg [SYNC_DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_DEPTH; gi++) begin : g_sync
            if (gi == 0) begin : g_head
                assign sync_in[gi] = {ram_ce, ram_oe_l, ram_we_l, ram_addr, ram_data};
            end else begin : g_tail
                assign sync_in[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < SYNC_DEPTH; i++) begin
            if (rst) begin
                sync_reg[i] <= SYNC_RST;
            end else begin
                sync_reg[i] <= sync_in[i];
            end
        end
    end

    ctrl_t             ctrl_s;
    logic [15:0]       addr_s;
    logic [DATA_W-1:0] data_s;

    assign {ctrl_s, addr_s, data_s} = sync_reg[SYNC_DEPTH-1];

    // Upper address bits alias onto the implemented depth.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_s[15:ADDR_W];

    // After reset the synchronizer holds forced idle levels; settle_reg marks
    // when its output reflects real pin values again.
    logic [SYNC_DEPTH-1:0] settle_reg;
    logic                  primed;

    always_ff @(posedge clk) begin
        if (rst) begin
            settle_reg <= '0;
        end else begin
            settle_reg <= {settle_reg[SYNC_DEPTH-2:0], 1'b1};
        end
    end

    assign primed = settle_reg[SYNC_DEPTH-1];

    // A write strobe still low across reset belongs to a discarded access;
    // new writes are refused until we_l has been seen high.
    logic wr_block_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_block_reg <= 1'b1;
        end else if (primed && ctrl_s.we_l) begin
            wr_block_reg <= 1'b0;
        end
    end

    logic [1:0] state_reg;
    logic [1:0] state_next;
    logic       capture;
    logic       commit;
    logic       start_rd;

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        commit     = 1'b0;
        start_rd   = 1'b0;
        if (is_conflict(ctrl_s)) begin
            state_next = ST_CONFLICT;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (is_write_req(ctrl_s) && !wr_block_reg) begin
                        state_next = ST_WRITE;
                        capture    = 1'b1;
                    end else if (is_read_req(ctrl_s)) begin
                        state_next = ST_READ;
                        start_rd   = 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (!ctrl_s.ce) begin
                        state_next = ST_IDLE;
                    end else if (ctrl_s.we_l) begin
                        state_next = ST_IDLE;
                        commit     = 1'b1;
                    end else begin
                        capture = 1'b1;
                    end
                end
                ST_READ: begin
                    if (ctrl_s.oe_l || !ctrl_s.ce) begin
                        state_next = ST_IDLE;
                    end
                end
                ST_CONFLICT: begin
                    if (!ctrl_s.ce || (ctrl_s.we_l && ctrl_s.oe_l)) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    logic [ADDR_W-1:0] cap_addr_reg;
    logic [DATA_W-1:0] cap_data_reg;
    logic [15:0]       wr_count_reg;
    logic [15:0]       rd_count_reg;
    logic              conflict_reg;
    logic              oe_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            wr_count_reg <= '0;
            rd_count_reg <= '0;
            conflict_reg <= 1'b0;
            oe_reg       <= 1'b0;
        end else begin
            state_reg <= state_next;
            oe_reg    <= (state_next == ST_READ);
            if (commit) begin
                wr_count_reg <= wr_count_reg + 16'd1;
            end
            if (start_rd) begin
                rd_count_reg <= rd_count_reg + 16'd1;
            end
            if (state_next == ST_CONFLICT) begin
                conflict_reg <= 1'b1;
            end
        end
    end

    // Capture registers need no reset: they are only consumed after a capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            cap_addr_reg <= addr_s[ADDR_W-1:0];
            cap_data_reg <= data_s;
        end
    end

    logic [DATA_W-1:0] rd_data;

    sram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (commit && !rst),
        .wr_addr (cap_addr_reg),
        .wr_data (cap_data_reg),
        .rd_addr (addr_s[ADDR_W-1:0]),
        .rd_data (rd_data)
    );

    assign ram_data = oe_reg ? rd_data : {DATA_W{1'bz}};
    assign wr_count = wr_count_reg;
    assign rd_count = rd_count_reg;
    assign conflict = conflict_reg;

endmodule
